mem_arbiter_nport: RTL and testbench

Parametrised N-port arbitrated on-chip memory controller. It is the successor to the fixed PCIe/core/ML three-port controller. It serves NUM_PORTS requesters (PCIe, softcore, ML accelerators, DMA) with valid/ready handshakes, selectable round-robin or fixed-priority arbitration, and a starvation guard. After reset it clears the memory through a hardware init sweep. It sits between the interconnect masters and a single-port synchronous RAM (BRAM/UltraRAM inference).

---
 rtl/mem_arbiter_nport_if.sv | 40 ++++
 rtl/mem_arbiter_nport.sv | 188 ++++++++++++++++++
 tb/tb_mem_arbiter_nport.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_nport_if.sv
// Request/response bundle for the N-port memory arbiter.
// BYTE_EN_EN adds per-byte write enables (req_be).
interface mem_arbiter_nport_if #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 16
);
  logic [NUM_PORTS-1:0]        req_valid;
  logic [NUM_PORTS-1:0]        req_we;
  logic [NUM_PORTS*ADDR_W-1:0] req_addr;
  logic [NUM_PORTS*DATA_W-1:0] req_wdata;
  logic [NUM_PORTS-1:0]        req_ready;
  logic [NUM_PORTS-1:0]        rsp_valid;
  logic [NUM_PORTS*DATA_W-1:0] rsp_data;
`ifdef BYTE_EN_EN
  logic [NUM_PORTS*DATA_W/8-1:0] req_be;

  modport master (
    output req_valid, req_we, req_addr,
    output req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_data
  );
  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_wdata, req_be,
    output req_ready, rsp_valid, rsp_data
  );
`else
  modport master (
    output req_valid, req_we, req_addr,
    output req_wdata,
    input  req_ready, rsp_valid, rsp_data
  );
  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_wdata,
    output req_ready, rsp_valid, rsp_data
  );
`endif
endinterface

// File: rtl/mem_arbiter_nport.sv
// N-port arbitrated single-port RAM controller with init sweep.
// Optional macro BYTE_EN_EN enables per-byte write masking.
module mem_arbiter_nport #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 8192,
  parameter int ADDR_W    = 16,
  parameter int MAX_WAIT  = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                arb_mode,
  input  logic [2:0]          prio_port,
  mem_arbiter_nport_if.slave  bus,
  output logic                init_done,
  output logic                mem_idle
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(NUM_PORTS);
  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic {INIT, RUN} state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       init_cnt_q, init_cnt_d;
  logic                init_done_q, mem_idle_q;
  logic                mode_q;
  logic [PW-1:0]       rr_q, rr_d;
  logic [WW-1:0]       wcnt_q [NUM_PORTS];
  logic [WW-1:0]       wcnt_d [NUM_PORTS];
  logic [NUM_PORTS-1:0] rsp_vld_q;
  logic                rd_pend_q, oor_q;
  logic [PW-1:0]       rd_port_q;
  logic [DATA_W-1:0]   ram_q, rdat;
  logic [DATA_W-1:0]   hold_q [NUM_PORTS];
  logic [DATA_W-1:0]   mem [DEPTH];

  logic [PW-1:0]       base, gnt_idx;
  logic                gnt_any, acc, run, oor;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                ram_we;
  logic [AW-1:0]       ram_addr;
  logic [DATA_W-1:0]   ram_wd;

  assign run = (state_q == RUN);

  always_comb begin
    base    = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (mode_q) begin
      if (int'(prio_port) < NUM_PORTS)
        base = prio_port[PW-1:0];
    end else begin
      base = rr_q;
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!gnt_any &&
          bus.req_valid[(int'(base) + i) % NUM_PORTS]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'((int'(base) + i) % NUM_PORTS);
      end
    end
    // Starved ports override priority; reverse scan so lowest index wins.
    if (mode_q) begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (bus.req_valid[i] && wcnt_q[i] == WW'(MAX_WAIT))
          gnt_idx = PW'(i);
      end
    end
  end

  assign acc       = run && init_done_q && gnt_any;
  assign sel_we    = bus.req_we[gnt_idx];
  assign sel_addr  = bus.req_addr[gnt_idx*ADDR_W +: ADDR_W];
  assign sel_wdata = bus.req_wdata[gnt_idx*DATA_W +: DATA_W];
  assign oor       = 32'(sel_addr) >= DEPTH;

  always_comb begin
    bus.req_ready = '0;
    if (acc)
      bus.req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    rr_d = rr_q;
    if (acc)
      rr_d = PW'((int'(gnt_idx) + 1) % NUM_PORTS);
    for (int p = 0; p < NUM_PORTS; p++) begin
      wcnt_d[p] = wcnt_q[p];
      if (!mode_q || !run || !bus.req_valid[p] ||
          (acc && gnt_idx == PW'(p)))
        wcnt_d[p] = '0;
      else if (wcnt_q[p] != WW'(MAX_WAIT))
        wcnt_d[p] = wcnt_q[p] + 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    unique case (state_q)
      INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == AW'(DEPTH - 1)) begin
          state_d    = RUN;
          init_cnt_d = '0;
        end
      end
      RUN: state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  assign ram_we   = rst_n &&
                    (!run || (acc && sel_we && !oor));
  assign ram_addr = run ? sel_addr[AW-1:0] : init_cnt_q;
  assign ram_wd   = run ? sel_wdata : '0;

`ifdef BYTE_EN_EN
  logic [DATA_W/8-1:0] ram_be;
  assign ram_be = run ?
    bus.req_be[gnt_idx*(DATA_W/8) +: DATA_W/8] : '1;

  always_ff @(posedge clk) begin
    for (int b = 0; b < DATA_W / 8; b++)
      if (ram_we && ram_be[b])
        mem[ram_addr][b*8 +: 8] <= ram_wd[b*8 +: 8];
    ram_q <= mem[ram_addr];
  end
`else
  always_ff @(posedge clk) begin
    if (ram_we)
      mem[ram_addr] <= ram_wd;
    ram_q <= mem[ram_addr];
  end
`endif

  assign rdat = oor_q ? '0 : ram_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      mem_idle_q  <= 1'b1;
      mode_q      <= 1'b0;
      rr_q        <= '0;
      rsp_vld_q   <= '0;
      rd_pend_q   <= 1'b0;
      rd_port_q   <= '0;
      oor_q       <= 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        wcnt_q[p] <= '0;
        hold_q[p] <= '0;
      end
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= run;
      mem_idle_q  <= run && !(|bus.req_valid) && !(|rsp_vld_q);
      mode_q      <= arb_mode;
      rr_q        <= rr_d;
      rsp_vld_q   <= bus.req_ready;
      rd_pend_q   <= acc && !sel_we;
      rd_port_q   <= gnt_idx;
      oor_q       <= oor;
      for (int p = 0; p < NUM_PORTS; p++)
        wcnt_q[p] <= wcnt_d[p];
      if (rd_pend_q)
        hold_q[rd_port_q] <= rdat;
    end
  end

  // Fresh read data bypasses the hold register in its response cycle.
  always_comb begin
    bus.rsp_data = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      bus.rsp_data[p*DATA_W +: DATA_W] =
        (rd_pend_q && rd_port_q == PW'(p)) ? rdat : hold_q[p];
  end

  assign bus.rsp_valid = rsp_vld_q;
  assign init_done     = init_done_q;
  assign mem_idle      = mem_idle_q;
endmodule

// File: tb/tb_mem_arbiter_nport.sv
// Directed bench for mem_arbiter_nport (default build, 4 ports).
// Expected values are hand-derived from the block behaviour.
module tb_mem_arbiter_nport;
  localparam int NP = 4;
  localparam int DW = 32;
  localparam int AWD = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       arb_mode = 1'b0;
  logic [2:0] prio_port = 3'd0;
  logic       init_done, mem_idle;
  int         n_chk = 0;
  int         n_bad = 0;

  mem_arbiter_nport_if #(
    .NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AWD)
  ) bus ();

  mem_arbiter_nport #(
    .NUM_PORTS(NP), .DATA_W(DW), .DEPTH(8192),
    .ADDR_W(AWD), .MAX_WAIT(15)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .arb_mode  (arb_mode),
    .prio_port (prio_port),
    .bus       (bus.slave),
    .init_done (init_done),
    .mem_idle  (mem_idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input int p, input logic v,
                         input logic we,
                         input logic [15:0] a,
                         input logic [31:0] d);
    bus.req_valid[p]             = v;
    bus.req_we[p]                = we;
    bus.req_addr[p*AWD +: AWD]   = a;
    bus.req_wdata[p*DW +: DW]    = d;
  endtask

  function automatic logic [31:0] rd(input int p);
    return bus.rsp_data[p*DW +: DW];
  endfunction

  // Counts edges from reset release until init_done, bounded.
  task automatic wait_init(output int n, output int viol);
    n = 0;
    viol = 0;
    while (!init_done && n < 9000) begin
      tick();
      n++;
      if (!init_done && bus.req_ready != '0) viol++;
      if (!init_done && mem_idle) viol++;
    end
  endtask

  initial begin
    int n, viol, g;
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
`ifdef BYTE_EN_EN
    bus.req_be    = '1;
`endif
    @(negedge clk);
    tick();
    tick();
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_rspv", bus.rsp_valid, 0);
    chk("rst_rspd", bus.rsp_data, 0);
    chk("rst_initd", init_done, 0);
    chk("rst_idle", mem_idle, 1);

    set_req(0, 1, 0, 16'h1FFF, 0);
    rst_n = 1'b1;
    wait_init(n, viol);
    chk("init_lat", n, 8193);
    chk("init_viol", viol, 0);
    #1 chk("first_gnt", bus.req_ready, 4'b0001);
    tick();
    chk("first_rspv", bus.rsp_valid, 4'b0001);
    chk("top_zero", rd(0), 0);

    set_req(0, 0, 0, 0, 0);
    set_req(1, 1, 1, 16'h0010, 32'hDEADBEEF);
    #1 chk("raw_wgnt", bus.req_ready, 4'b0010);
    tick();
    chk("raw_wrsp", bus.rsp_valid, 4'b0010);
    set_req(1, 0, 0, 0, 0);
    set_req(0, 1, 0, 16'h0010, 0);
    #1 chk("raw_rgnt", bus.req_ready, 4'b0001);
    tick();
    chk("raw_rrsp", bus.rsp_valid, 4'b0001);
    chk("raw_data", rd(0), 32'hDEADBEEF);
    chk("wr_nodata", rd(1), 0);

    set_req(0, 0, 0, 0, 0);
    set_req(2, 1, 1, 16'h2000, 32'h12345678);
    #1 chk("oor_wgnt", bus.req_ready, 4'b0100);
    tick();
    chk("oor_wrsp", bus.rsp_valid, 4'b0100);
    set_req(2, 1, 0, 16'h2000, 0);
    tick();
    chk("oor_rrsp", bus.rsp_valid, 4'b0100);
    chk("oor_rdat", rd(2), 0);
    set_req(2, 1, 0, 16'h0000, 0);
    tick();
    chk("oor_alias", rd(2), 0);
    chk("hold0", rd(0), 32'hDEADBEEF);

    // Last grant was port 2, so round-robin resumes at 3.
    for (int p = 0; p < NP; p++) set_req(p, 1, 0, 16'(p), 0);
    for (int k = 0; k < 8; k++) begin
      g = (k + 3) % 4;
      #1 chk($sformatf("rr_gnt%0d", k), bus.req_ready, 1 << g);
      tick();
      chk($sformatf("rr_rsp%0d", k), bus.rsp_valid, 1 << g);
    end

    bus.req_valid = '0;
    arb_mode  = 1'b1;
    prio_port = 3'd2;
    tick();
    bus.req_valid = 4'b1100;
    for (int k = 0; k < 32; k++) begin
      g = (k % 16 == 15) ? 3 : 2;
      #1 chk($sformatf("fx_gnt%0d", k), bus.req_ready, 1 << g);
      tick();
    end
    bus.req_valid = '0;
    tick();
    prio_port = 3'd5;
    bus.req_valid = 4'b0110;
    #1 chk("prio_oob", bus.req_ready, 4'b0010);
    prio_port = 3'd3;
    bus.req_valid = 4'b0011;
    #1 chk("prio_wrap", bus.req_ready, 4'b0001);

    arb_mode = 1'b0;
    bus.req_valid = '0;
    set_req(0, 1, 0, 16'h0010, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rspv", bus.rsp_valid, 0);
    chk("mid_initd", init_done, 0);
    wait_init(n, viol);
    chk("reinit_lat", n, 8193);
    chk("reinit_viol", viol, 0);
    tick();
    chk("swept_rspv", bus.rsp_valid, 4'b0001);
    chk("swept_data", rd(0), 0);
    bus.req_valid = '0;
    tick();
    tick();
    chk("idle_end", mem_idle, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
